// File: rtl/cpu_host_pkg.sv
// Shared types and default parameters for the CPU host sequencer.
// host_state_t : the eight sequencer states.
// DEF_*        : default values for the cpu_host_seq parameters.
// cnt_width    : width of a counter that must hold 0..n.
package cpu_host_pkg;

  localparam int DEF_ADDR_W    = 6;
  localparam int DEF_LOAD_LEN  = 32;
  localparam int DEF_RES_BASE  = 32;
  localparam int DEF_RES_LEN   = 8;
  localparam int DEF_START_CYC = 2;
  localparam int DEF_TIMEOUT   = 4096;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_RUN     = 3'd3,
    ST_RD_REQ  = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_OUT     = 3'd6,
    ST_ERR     = 3'd7
  } host_state_t;

  // Width of a counter that must represent every value in 0..n (minimum 1 bit).
  function automatic int cnt_width(input int n);
    if (n < 1) begin
      return 1;
    end else begin
      return $clog2(n + 1);
    end
  endfunction

endpackage

// File: rtl/cpu_host_seq_run_watchdog.sv
// RUN-phase watchdog for the CPU host sequencer.
// clk, rst_n : clock and synchronous active-low reset
// clr        : zero the counter (held during START so RUN begins at 0)
// en         : count one RUN cycle
// expired    : counter has reached TIMEOUT-1
// first      : counter is 0, i.e. this is the first RUN cycle
module run_watchdog
  import cpu_host_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired,
  output logic first
);

  localparam int W = $clog2(TIMEOUT) + 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired = (cnt_q == W'(TIMEOUT - 1));
  assign first   = (cnt_q == {W{1'b0}});

  // Next count: clear wins, then count up, saturating once expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else if (en && !expired) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_host_seq.sv
// Host-side sequencer for a small CPU: preloads data memory from a byte
// stream, pulses start, waits for done under a watchdog, then streams a
// result window of data memory back to the host.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   go                    begin a load/run/drain sequence (IDLE only)
//   in_valid/in_data/in_ready     load byte stream
//   start, done           CPU handshake
//   mem_we/mem_addr/mem_wdata/mem_rdata  data memory port (1-cycle read)
//   out_valid/out_data/out_ready  result byte stream
//   busy                  any state other than IDLE
//   timeout               sticky watchdog abort flag, cleared by next go
// START_CYC must be at least 1.
module cpu_host_seq
  import cpu_host_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LOAD_LEN  = DEF_LOAD_LEN,
  parameter int RES_BASE  = DEF_RES_BASE,
  parameter int RES_LEN   = DEF_RES_LEN,
  parameter int START_CYC = DEF_START_CYC,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              start,
  input  logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              timeout
);

  localparam int LCNT_W = cnt_width(LOAD_LEN);
  localparam int IDX_W  = cnt_width(RES_LEN);
  localparam int SCNT_W = cnt_width(START_CYC);
  localparam bit LOAD_EMPTY = (LOAD_LEN == 0);
  localparam bit RES_EMPTY  = (RES_LEN == 0);

  host_state_t       state_q, state_d;
  logic [LCNT_W-1:0] cnt_q, cnt_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              timeout_q, timeout_d;
  logic              wd_clr, wd_en, wd_expired, wd_first;

  run_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired),
    .first   (wd_first)
  );

  assign out_data = out_data_q;
  assign timeout  = timeout_q;

  // Next-state, counters and port decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    scnt_d     = scnt_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    timeout_d  = timeout_q;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = {ADDR_W{1'b0}};
    mem_wdata  = 8'h00;
    start      = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (go) begin
          timeout_d = 1'b0;
          cnt_d     = {LCNT_W{1'b0}};
          state_d   = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (LOAD_EMPTY) begin
          scnt_d  = {SCNT_W{1'b0}};
          state_d = ST_START;
        end else begin
          // rst_n gates the write so a reset cycle never lands a byte.
          in_ready = rst_n;
          if (in_valid && rst_n) begin
            mem_we    = 1'b1;
            mem_addr  = ADDR_W'(cnt_q);
            mem_wdata = in_data;
            cnt_d     = cnt_q + LCNT_W'(1);
            if (cnt_q == LCNT_W'(LOAD_LEN - 1)) begin
              scnt_d  = {SCNT_W{1'b0}};
              state_d = ST_START;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_START: begin
        start  = 1'b1;
        wd_clr = 1'b1;
        if (scnt_q == SCNT_W'(START_CYC - 1)) begin
          state_d = ST_RUN;
        end else begin
          scnt_d = scnt_q + SCNT_W'(1);
        end
      end
      ST_RUN: begin
        wd_en = 1'b1;
        // A done already high on the first RUN cycle may be left over
        // from the previous program, so it is not trusted.
        if (!wd_first && done) begin
          idx_d   = {IDX_W{1'b0}};
          state_d = RES_EMPTY ? ST_IDLE : ST_RD_REQ;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_ERR;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RD_REQ: begin
        mem_addr = ADDR_W'(RES_BASE) + ADDR_W'(idx_q);
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        out_data_d = mem_rdata;
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx_q == IDX_W'(RES_LEN - 1)) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_RD_REQ;
          end
        end else begin
          state_d = ST_OUT;
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {LCNT_W{1'b0}};
      scnt_q     <= {SCNT_W{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      out_data_q <= 8'h00;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      scnt_q     <= scnt_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_cpu_host_seq.sv
module tb_cpu_host_seq;

  localparam int AW = 6;
  localparam int LL = 32;
  localparam int RB = 32;
  localparam int RL = 8;
  localparam int SC = 2;
  localparam int TO = 16;
  localparam int MS = 1 << AW;

  logic          clk;
  logic          rst_n, go, in_valid, in_ready, start, done, mem_we;
  logic [7:0]    in_data, mem_wdata, mem_rdata, out_data;
  logic [AW-1:0] mem_addr;
  logic          out_valid, out_ready, busy, timeout;

  logic [7:0]    mem [0:MS-1];
  logic [7:0]    model_mem [0:MS-1];
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;

  logic [15:0] exp_wr[$];
  logic [7:0]  exp_out[$];
  int          exp_wd[$];

  int   n_tests = 0;
  int   n_fail = 0;
  int   bound_hits = 0;
  bit   pr_idle, pr_mem, pr_flags, pr_final;
  logic [1:0] pr_flags_exp;

  cpu_host_seq #(.ADDR_W(AW), .LOAD_LEN(LL), .RES_BASE(RB), .RES_LEN(RL),
                 .START_CYC(SC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start), .done(done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data memory: sequencer port plus a CPU-side write port, registered read
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (cpu_we) mem[cpu_addr] <= cpu_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: the only process that compares
  initial begin : monitor
    int   st_cnt;
    bit   st_prev;
    bit   in_run;
    int   run_cnt;
    bit   stall_prev;
    logic [7:0]  stall_data;
    logic [15:0] ew;
    st_cnt = 0; st_prev = 1'b0; in_run = 1'b0; run_cnt = 0;
    stall_prev = 1'b0; stall_data = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          check("write_allowed", 32'(mem_we), 32'd0);
        end else begin
          ew = exp_wr.pop_front();
          check("write_addr_data", {16'd0, 2'b00, mem_addr, mem_wdata}, {16'd0, ew});
        end
      end
      if (start) check("start_port_idle", {25'd0, mem_we, mem_addr}, 32'd0);
      if (start) begin
        st_cnt++;
      end else if (st_prev) begin
        check("start_width", st_cnt, SC);
        st_cnt = 0;
        in_run = 1'b1;
        run_cnt = 0;
      end
      if (in_run) begin
        if (timeout) begin
          check("err_busy", 32'(busy), 32'd1);
          if (exp_wd.size() == 0) check("timeout_allowed", 32'(timeout), 32'd0);
          else check("watchdog_run_cycles", run_cnt, exp_wd.pop_front());
          in_run = 1'b0;
        end else if (out_valid) begin
          in_run = 1'b0;
        end else begin
          run_cnt++;
        end
      end
      if (stall_prev) check("out_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, stall_data});
      if (out_valid && exp_out.size() == 0) begin
        check("out_valid_allowed", 32'(out_valid), 32'd0);
      end else if (out_valid && out_ready) begin
        check("out_byte", 32'(out_data), 32'(exp_out.pop_front()));
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (pr_idle)
        check("reset_outputs", {4'd0, in_ready, start, mem_we, mem_addr, mem_wdata,
                                out_valid, out_data, busy, timeout}, 32'd0);
      if (pr_flags) check("busy_timeout", {30'd0, busy, timeout}, {30'd0, pr_flags_exp});
      if (pr_mem) for (int i = 0; i < LL; i++) check("mem_image", 32'(mem[i]), 32'(model_mem[i]));
      if (pr_final) begin
        check("writes_outstanding", exp_wr.size(), 0);
        check("bytes_outstanding", exp_out.size(), 0);
        check("timeouts_outstanding", exp_wd.size(), 0);
        check("wait_bounds_expired", bound_hits, 0);
      end
      st_prev = start;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bound_fail(input string what, input int waited);
    bound_hits++;
    $display("FAIL wait_%s: waited %0d cycles, no response", what, waited);
  endtask

  task automatic run_seq(input bit incr, input bit bp, input bit hold3,
                         input bit nodone, input bit rrand);
    int n;
    int hs;
    int hold_n;
    int dly;
    logic [7:0] b;
    go = 1'b1; tick(); go = 1'b0;
    pr_flags = 1'b1; pr_flags_exp = 2'b10; tick(); pr_flags = 1'b0;
    for (int i = 0; i < LL; i++) begin
      if (bp) begin in_valid = 1'b0; tick(); end
      b = incr ? 8'(i) : 8'($urandom_range(0, 255));
      in_valid = 1'b1; in_data = b; model_mem[i] = b;
      exp_wr.push_back({8'(i), b});
      go = ($urandom_range(0, 3) == 0);
      n = 0;
      while (!in_ready && n < 8) begin tick(); n++; end
      if (!in_ready) bound_fail("in_ready", n);
      tick();
    end
    in_valid = 1'b0; go = 1'b0;
    pr_mem = 1'b1; tick(); pr_mem = 1'b0;
    n = 0;
    while (start && n < 20) begin tick(); n++; end
    if (start) bound_fail("start_fall", n);
    if (!nodone) begin
      for (int k = 0; k < RL; k++) begin
        cpu_we = 1'b1; cpu_addr = AW'(RB + k);
        cpu_wdata = incr ? 8'(8'hA0 + k) : 8'($urandom_range(0, 255));
        model_mem[(RB + k) % MS] = cpu_wdata;
        tick();
      end
      cpu_we = 1'b0;
      for (int k = 0; k < RL; k++) exp_out.push_back(model_mem[(RB + k) % MS]);
      dly = incr ? 2 : $urandom_range(0, 4);
      repeat (dly) tick();
      done = 1'b1;
      hs = 0; hold_n = 0; n = 0;
      while (hs < RL && n < 400) begin
        if (hold3 && hs == 3 && out_valid && hold_n < 5) begin
          out_ready = 1'b0; hold_n++;
        end else if (rrand) begin
          out_ready = ($urandom_range(0, 2) != 0);
        end else begin
          out_ready = 1'b1;
        end
        if (out_valid) done = 1'b0;
        if (out_valid && out_ready) hs++;
        tick(); n++;
      end
      out_ready = 1'b0; done = 1'b0;
      if (hs < RL) bound_fail("drain", n);
      pr_flags = 1'b1; pr_flags_exp = 2'b00; tick(); pr_flags = 1'b0;
    end else begin
      exp_wd.push_back(TO);
      out_ready = 1'b1;
      n = 0;
      while (!timeout && n < TO + 8) begin tick(); n++; end
      if (!timeout) bound_fail("timeout", n);
      tick();
      pr_flags = 1'b1; pr_flags_exp = 2'b01; tick();
      tick(); pr_flags = 1'b0;
      out_ready = 1'b0;
    end
  endtask

  task automatic reset_mid_load();
    logic [7:0] b;
    go = 1'b1; tick(); go = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(0, 255));
      in_valid = 1'b1; in_data = b; model_mem[i] = b;
      exp_wr.push_back({8'(i), b});
      tick();
    end
    in_data = 8'h5A; rst_n = 1'b0; tick();
    pr_idle = 1'b1; tick(); pr_idle = 1'b0;
    rst_n = 1'b1; in_valid = 1'b0; tick();
  endtask

  initial begin : stim
    rst_n = 1'b0; go = 1'b0; in_valid = 1'b0; in_data = 8'h00; done = 1'b0;
    out_ready = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
    pr_idle = 1'b0; pr_mem = 1'b0; pr_flags = 1'b0; pr_final = 1'b0; pr_flags_exp = 2'b00;
    tick(); tick();
    pr_idle = 1'b1; tick(); pr_idle = 1'b0;
    rst_n = 1'b1; tick();
    run_seq(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_seq(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_seq(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_seq(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_seq(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    reset_mid_load();
    for (int r = 0; r < 5; r++)
      run_seq(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    repeat (3) tick();
    pr_final = 1'b1; tick(); pr_final = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
